// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared pipeline-control constants and the mult/div state type.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int C_REG_ADDR_W    = 5;
    localparam int C_MULDIV_CYCLES = 32;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_timer.sv
// ============================================================================
// Module      : muldiv_timer
// Description : Tracks an in-flight mult/div operation and pulses done on its
//               final cycle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_timer
    import cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = C_MULDIV_CYCLES,
    parameter int CNT_W         = 6
)(
    input  logic clk,
    input  logic rst,
    input  logic issue,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    md_state_e        r_st;
    logic [CNT_W-1:0] r_cnt;

    // issue is only honoured from RUN; a new request in MD_BUSY waits for done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st  <= RUN;
            r_cnt <= '0;
        end else begin
            case (r_st)
                RUN: begin
                    if (issue) begin
                        r_st  <= MD_BUSY;
                        r_cnt <= C_CNT_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt == '0) begin
                        r_st <= RUN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_st  <= RUN;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (r_st == MD_BUSY);
    assign done = (r_st == MD_BUSY) && (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/stall_ctrl.sv
// ============================================================================
// Module      : stall_ctrl
// Description : Load-use / mult-div hazard detection and PC, IF/ID, ID/EX
//               enable and flush control.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stall_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W    = C_REG_ADDR_W,
    parameter int MULDIV_CYCLES = C_MULDIV_CYCLES,
    parameter int CNT_W         = 6
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  id_muldiv,
    input  logic                  id_hilo_read,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  muldiv_busy,
    output logic                  muldiv_done
);

    logic w_lu;
    logic w_md;
    logic w_issue;
    logic w_busy;
    logic w_done;

    assign w_lu = ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    // A HI/LO reader or a second mult/div must wait until the unit is back in RUN.
    assign w_md    = w_busy && (id_muldiv || id_hilo_read);
    assign w_issue = id_muldiv && !w_lu && !ex_branch_taken;

    muldiv_timer #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_muldiv_timer (
        .clk   (clk),
        .rst   (rst),
        .issue (w_issue),
        .busy  (w_busy),
        .done  (w_done)
    );

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        muldiv_busy = w_busy;
        muldiv_done = w_done;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            muldiv_busy = 1'b0;
            muldiv_done = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_lu || w_md) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stall_ctrl.sv
// ============================================================================
// Module      : tb_stall_ctrl
// Description : Directed self-checking bench for stall_ctrl (MULDIV_CYCLES=4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_muldiv, id_hilo_read, ex_memread, ex_branch_taken;
    logic       pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy, muldiv_done;
    logic [5:0] w_obs;

    int r_checks = 0;
    int r_errors = 0;

    // Expected vectors are {pc_en, ifid_en, ifid_flush, idex_flush, busy, done}.
    localparam logic [5:0] C_OFF   = 6'b000000;
    localparam logic [5:0] C_IDLE  = 6'b110000;
    localparam logic [5:0] C_STALL = 6'b000100;
    localparam logic [5:0] C_BR    = 6'b111100;

    stall_ctrl #(
        .REG_ADDR_W    (5),
        .MULDIV_CYCLES (4),
        .CNT_W         (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .id_muldiv       (id_muldiv),
        .id_hilo_read    (id_hilo_read),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done)
    );

    always #5 clk = ~clk;

    assign w_obs = {pc_en, ifid_en, ifid_flush, idex_flush, muldiv_busy, muldiv_done};

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        r_checks++;
        if (obs !== exp) begin
            r_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rt = 1'b0; id_muldiv = 1'b0; id_hilo_read = 1'b0;
        ex_memread = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [5:0] exp);
        #2;
        chk(tag, w_obs, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("reset_hold", w_obs, C_OFF);
        tick();
        rst = 1'b0;
        cyc("after_reset", C_IDLE);

        // Load-use on rs: one stall cycle, then the load has left EX.
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc("lu_rs", C_STALL);
        idle();
        cyc("lu_release", C_IDLE);

        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cyc("lu_r0", C_IDLE);

        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        cyc("lu_rt_unused", C_IDLE);
        id_uses_rt = 1'b1;
        cyc("lu_rt_used", C_STALL);
        ex_memread = 1'b0;
        cyc("no_memread", C_IDLE);

        idle();
        ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
        cyc("branch_over_lu", C_BR);
        idle();

        // A mult/div alongside a taken branch must not issue.
        id_muldiv = 1'b1; ex_branch_taken = 1'b1;
        cyc("branch_blocks_issue", C_BR);
        idle();
        cyc("no_issue_after_branch", C_IDLE);

        // Mult/div at T with an mfhi following from T+1.
        id_muldiv = 1'b1;
        cyc("md_issue_T", C_IDLE);
        id_muldiv = 1'b0; id_hilo_read = 1'b1;
        cyc("md_T1", 6'b000110);
        cyc("md_T2", 6'b000110);
        cyc("md_T3", 6'b000110);
        cyc("md_T4_done", 6'b000111);
        cyc("md_T5_release", C_IDLE);
        idle();

        // Branch mid-operation plus a second mult/div held until done.
        id_muldiv = 1'b1;
        cyc("b2b_issue_T", C_IDLE);
        id_muldiv = 1'b0; ex_branch_taken = 1'b1;
        cyc("b2b_T1_branch", 6'b111110);
        idle();
        cyc("b2b_T2", 6'b110010);
        id_muldiv = 1'b1;
        cyc("b2b_T3_held", 6'b000110);
        cyc("b2b_T4_done", 6'b000111);
        cyc("b2b_T5_issue", C_IDLE);
        id_muldiv = 1'b0;
        cyc("b2b_T6_busy", 6'b110010);
        cyc("b2b_T7", 6'b110010);
        cyc("b2b_T8", 6'b110010);
        cyc("b2b_T9_done", 6'b110011);
        cyc("b2b_T10_idle", C_IDLE);

        // Asynchronous reset mid-cycle at T+2 aborts the operation.
        id_muldiv = 1'b1;
        cyc("abort_issue_T", C_IDLE);
        id_muldiv = 1'b0;
        cyc("abort_T1", 6'b110010);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_async_rst", w_obs, C_OFF);
        tick();
        rst = 1'b0;
        cyc("abort_T3", C_IDLE);
        cyc("abort_T4_no_done", C_IDLE);
        cyc("abort_T5", C_IDLE);

        $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
        $finish;
    end

endmodule

`default_nettype wire
